// File: rtl/buffer_pingpong_pkg.sv
// Shared types for the ping-pong buffer sequencer: FSM state encodings and bank sizing helper.
package buffer_pingpong_pkg;

  typedef enum logic {W_IDLE, W_FILL} wr_state_e;

  typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} rd_state_e;

  // Bank index width: the address MSB selects the bank, the rest index within it.
  function automatic int unsigned bank_w(input int unsigned addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/buffer_pingpong_ctrl_if.sv
// Stream, control and RAM-port bundle for buffer_pingpong_ctrl.
// BUFFER_PINGPONG_CTRL_OVF_CNT_EN adds the oovf_cnt drop counter.
interface buffer_pingpong_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 18
);
  logic [ADDR_W-2:0] iframe_len;
  logic              ivalid;
  logic [DATA_W-1:0] idata;
  logic              iready;
  logic              ovalid;
  logic [DATA_W-1:0] odata;
  logic              olast;
  logic              oovf;
  logic              iovf_clr;
  logic              oram_en_wr;
  logic [ADDR_W-1:0] oram_wr_addr;
  logic [DATA_W-1:0] oram_wdata;
  logic              oram_en_rd;
  logic [ADDR_W-1:0] oram_r_addr;
  logic [DATA_W-1:0] iram_rdata;
`ifdef BUFFER_PINGPONG_CTRL_OVF_CNT_EN
  logic [15:0]       oovf_cnt;

  modport master (
    input  iframe_len, ivalid, idata, iready, iovf_clr, iram_rdata,
    output ovalid, odata, olast, oovf, oram_en_wr, oram_wr_addr, oram_wdata,
    output oram_en_rd, oram_r_addr, oovf_cnt
  );
  modport slave (
    output iframe_len, ivalid, idata, iready, iovf_clr, iram_rdata,
    input  ovalid, odata, olast, oovf, oram_en_wr, oram_wr_addr, oram_wdata,
    input  oram_en_rd, oram_r_addr, oovf_cnt
  );
`else
  modport master (
    input  iframe_len, ivalid, idata, iready, iovf_clr, iram_rdata,
    output ovalid, odata, olast, oovf, oram_en_wr, oram_wr_addr, oram_wdata,
    output oram_en_rd, oram_r_addr
  );
  modport slave (
    output iframe_len, ivalid, idata, iready, iovf_clr, iram_rdata,
    input  ovalid, odata, olast, oovf, oram_en_wr, oram_wr_addr, oram_wdata,
    input  oram_en_rd, oram_r_addr
  );
`endif
endinterface

// File: rtl/buffer_pingpong_ctrl.sv
// Ping-pong sequencer: fills one RAM bank from the input stream while streaming the other out.
// BUFFER_PINGPONG_CTRL_OVF_CNT_EN adds a saturating dropped-sample counter on oovf_cnt.
module buffer_pingpong_ctrl
  import buffer_pingpong_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 18
) (
  input logic                  iclk,
  input logic                  irst_n,
  buffer_pingpong_ctrl_if.master bus
);

  localparam int unsigned BANK_W = bank_w(ADDR_W);

  wr_state_e         w_state_q;
  logic [BANK_W-1:0] w_len_q, wcnt_q;
  logic              wr_bank_q;
  logic [1:0]        bank_full_q;
  logic [BANK_W-1:0] bank_len_q [2];

  rd_state_e         r_state_q;
  logic [BANK_W-1:0] r_len_q, rcnt_q;
  logic              rd_bank_q;
  logic              ovalid_q, olast_q, oovf_q;

  logic              w_blocked, w_accept, w_drop, w_done;
  logic [BANK_W-1:0] w_idx, w_cur_len;
  logic              r_start, r_issue, r_free, r_last;
  logic [BANK_W-1:0] r_cur_len;

  // Write side: a fill may only start on a free bank; once started it never stalls.
  always_comb begin
    w_blocked = (w_state_q == W_IDLE) && bank_full_q[wr_bank_q];
    w_accept  = irst_n && bus.ivalid && !w_blocked;
    w_drop    = irst_n && bus.ivalid && w_blocked;
    w_idx     = (w_state_q == W_IDLE) ? '0 : wcnt_q;
    w_cur_len = (w_state_q == W_IDLE) ? bus.iframe_len : w_len_q;
    w_done    = w_accept && (w_idx == w_cur_len);
  end

  always_comb begin
    r_start   = (r_state_q == R_IDLE) && bank_full_q[rd_bank_q];
    r_issue   = irst_n && (r_start || ((r_state_q == R_READ) && (!ovalid_q || bus.iready)));
    r_free    = (r_state_q == R_DRAIN) && ovalid_q && bus.iready;
    r_cur_len = (r_state_q == R_IDLE) ? bank_len_q[rd_bank_q] : r_len_q;
    r_last    = (rcnt_q == r_cur_len);
  end

  assign bus.oram_en_wr   = w_accept;
  assign bus.oram_wr_addr = {wr_bank_q, w_idx};
  assign bus.oram_wdata   = DATA_W'(bus.idata);
  assign bus.oram_en_rd   = r_issue;
  assign bus.oram_r_addr  = {rd_bank_q, rcnt_q};
  assign bus.odata        = DATA_W'(bus.iram_rdata);
  assign bus.ovalid       = ovalid_q;
  assign bus.olast        = olast_q;
  assign bus.oovf         = oovf_q;

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      w_state_q     <= W_IDLE;
      w_len_q       <= '0;
      wcnt_q        <= '0;
      wr_bank_q     <= 1'b0;
      bank_len_q[0] <= '0;
      bank_len_q[1] <= '0;
    end else if (w_accept) begin
      if (w_state_q == W_IDLE) w_len_q <= bus.iframe_len;
      if (w_done) begin
        w_state_q             <= W_IDLE;
        wcnt_q                <= '0;
        wr_bank_q             <= ~wr_bank_q;
        bank_len_q[wr_bank_q] <= w_cur_len;
      end else begin
        w_state_q <= W_FILL;
        wcnt_q    <= w_idx + 1'b1;
      end
    end
  end

  // Set and clear never target the same bank: the writer only completes a bank that was free.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      bank_full_q <= '0;
    end else begin
      if (w_done) bank_full_q[wr_bank_q] <= 1'b1;
      if (r_free) bank_full_q[rd_bank_q] <= 1'b0;
    end
  end

  // The first read is issued straight from R_IDLE to keep the fill-to-output latency at two clocks.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      r_state_q <= R_IDLE;
      r_len_q   <= '0;
      rcnt_q    <= '0;
      rd_bank_q <= 1'b0;
      ovalid_q  <= 1'b0;
      olast_q   <= 1'b0;
    end else if (r_issue) begin
      if (r_state_q == R_IDLE) r_len_q <= r_cur_len;
      ovalid_q <= 1'b1;
      olast_q  <= r_last;
      if (r_last) begin
        rcnt_q    <= '0;
        r_state_q <= R_DRAIN;
      end else begin
        rcnt_q    <= rcnt_q + 1'b1;
        r_state_q <= R_READ;
      end
    end else if (r_free) begin
      ovalid_q  <= 1'b0;
      olast_q   <= 1'b0;
      rd_bank_q <= ~rd_bank_q;
      r_state_q <= R_IDLE;
    end
  end

  always_ff @(posedge iclk) begin
    if (!irst_n)           oovf_q <= 1'b0;
    else if (w_drop)       oovf_q <= 1'b1;
    else if (bus.iovf_clr) oovf_q <= 1'b0;
  end

`ifdef BUFFER_PINGPONG_CTRL_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      ovf_cnt_q <= '0;
    end else if (w_drop) begin
      if (bus.iovf_clr)               ovf_cnt_q <= 16'd1;
      else if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end else if (bus.iovf_clr) begin
      ovf_cnt_q <= '0;
    end
  end

  assign bus.oovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_buffer_pingpong_ctrl.sv
// Bench for buffer_pingpong_ctrl: directed phases plus random traffic against a frame-queue model.
module tb_buffer_pingpong_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int          BANK   = 1 << (ADDR_W - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  buffer_pingpong_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  buffer_pingpong_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .iclk  (clk),
    .irst_n(rst_n),
    .bus   (bus)
  );

  // Dual-port RAM with registered read output.
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  always @(posedge clk) begin
    if (bus.oram_en_wr) mem[bus.oram_wr_addr] <= bus.oram_wdata;
    if (bus.oram_en_rd) bus.iram_rdata <= mem[bus.oram_r_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: completed frames wait in a sample queue with their lengths alongside.
  logic [31:0] full_q[$];
  int          len_q[$];
  logic [31:0] cur_q[$];
  int          cur_len = 0;
  bit          filling = 0;
  int          fills_done = 0;
  bit          rd_busy = 0;
  int          rd_idx = 0;
  bit          m_valid = 0;
  logic [31:0] m_data = '0;
  bit          m_last = 0;
  bit          m_ovf = 0;
  int          m_cnt = 0;

  logic        t_v, t_rdy, t_clr, t_rst;
  logic [31:0] t_d;
  int          t_len;

  function automatic bit exp_accept();
    return t_rst && t_v && (filling || len_q.size() < 2);
  endfunction

  task automatic model_reset();
    full_q.delete(); len_q.delete(); cur_q.delete();
    filling = 0; fills_done = 0; rd_busy = 0; rd_idx = 0;
    m_valid = 0; m_last = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic model_issue();
    m_data  = full_q[rd_idx];
    m_last  = (rd_idx == len_q[0] - 1);
    m_valid = 1;
    rd_idx++;
  endtask

  task automatic model_step();
    bit acc, drop;
    if (!t_rst) begin
      model_reset();
      return;
    end
    acc  = exp_accept();
    drop = t_v && !acc;
    // Read side sees the frame list as it stood before this edge.
    if (!m_valid || t_rdy) begin
      if (m_valid && t_rdy && m_last) begin
        repeat (len_q[0]) void'(full_q.pop_front());
        void'(len_q.pop_front());
        m_valid = 0; m_last = 0; rd_busy = 0; rd_idx = 0;
      end else if (rd_busy && rd_idx < len_q[0]) begin
        model_issue();
      end else if (!rd_busy && len_q.size() > 0) begin
        rd_busy = 1; rd_idx = 0;
        model_issue();
      end else begin
        m_valid = 0;
      end
    end
    if (acc) begin
      if (!filling) begin
        cur_q.delete();
        cur_len = t_len + 1;
        filling = 1;
      end
      cur_q.push_back(t_d);
      if (cur_q.size() == cur_len) begin
        foreach (cur_q[i]) full_q.push_back(cur_q[i]);
        len_q.push_back(cur_len);
        cur_q.delete();
        filling = 0;
        fills_done++;
      end
    end
    if (drop) begin
      m_ovf = 1;
      m_cnt = t_clr ? 1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1);
    end else if (t_clr) begin
      m_ovf = 0;
      m_cnt = 0;
    end
  endtask

  task automatic check_outputs();
    bit acc;
    acc = exp_accept();
    check_eq("ovalid", bus.ovalid, m_valid);
    if (m_valid) begin
      check_eq("odata", bus.odata, m_data);
      check_eq("olast", bus.olast, m_last);
    end
    check_eq("oovf", bus.oovf, m_ovf);
    check_eq("wr_en", bus.oram_en_wr, acc);
    if (acc) begin
      check_eq("wr_addr", bus.oram_wr_addr, (fills_done % 2) * BANK + (filling ? cur_q.size() : 0));
      check_eq("wdata", bus.oram_wdata, t_d);
    end
`ifdef BUFFER_PINGPONG_CTRL_OVF_CNT_EN
    check_eq("ovf_cnt", bus.oovf_cnt, m_cnt);
`endif
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic rdy, input int len,
                       input logic clr, input logic rst);
    @(negedge clk);
    t_v = v; t_d = d; t_rdy = rdy; t_len = len; t_clr = clr; t_rst = rst;
    bus.ivalid     = v;
    bus.idata      = d;
    bus.iready     = rdy;
    bus.iframe_len = len[ADDR_W-2:0];
    bus.iovf_clr   = clr;
    rst_n          = rst;
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    bus.ivalid = 0; bus.idata = '0; bus.iready = 1; bus.iframe_len = '0; bus.iovf_clr = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);

    cycle(0, 0, 1, 3, 0, 0);
    cycle(0, 0, 1, 3, 0, 1);

    // Two full frames with continuous ready.
    for (int i = 1; i <= 8; i++) cycle(1, i, 1, 3, 0, 1);
    repeat (20) cycle(0, 0, 1, 3, 0, 1);

    // Ready toggling every clock during readout.
    for (int i = 1; i <= 8; i++) cycle(1, 100 + i, i[0], 3, 0, 1);
    for (int i = 0; i < 30; i++) cycle(0, 0, i[0], 3, 0, 1);

    // Stalled consumer: samples beyond two banks are dropped, then clear and drain.
    for (int i = 1; i <= 12; i++) cycle(1, 200 + i, 0, 3, 0, 1);
    cycle(0, 0, 0, 3, 0, 1);
    cycle(0, 0, 0, 3, 1, 1);
    cycle(0, 0, 0, 3, 0, 1);
    repeat (30) cycle(0, 0, 1, 3, 0, 1);

    // Single-sample frames back to back; banks free while writes wait.
    for (int i = 1; i <= 20; i++) cycle(1, 300 + i, 1, 0, 0, 1);
    repeat (10) cycle(0, 0, 1, 0, 1, 1);

    // Reset in the middle of readout, then a fresh frame.
    for (int i = 1; i <= 8; i++) cycle(1, 400 + i, 1, 3, 0, 1);
    repeat (2) cycle(0, 0, 1, 3, 0, 1);
    cycle(0, 0, 1, 3, 0, 0);
    cycle(0, 0, 1, 3, 0, 1);
    for (int i = 1; i <= 4; i++) cycle(1, 500 + i, 1, 3, 0, 1);
    repeat (10) cycle(0, 0, 1, 3, 0, 1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 70,
            $urandom_range(0, BANK - 1), $urandom_range(0, 99) < 3,
            $urandom_range(0, 499) != 0);
    end
    repeat (40) cycle(0, 0, 1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/buffer_pingpong_ctrl.md
Name: buffer_pingpong_ctrl

Overview:
- Single-clock ping-pong sequencer for the dual-port sample buffer RAM.
- Splits the RAM into two banks using the address MSB, then alternates between them:
  - Write side: fills one bank with an incoming sample stream.
  - Read side: streams the other bank out, honouring valid/ready backpressure.
- Sits between the sync front-end sample stream and downstream DSP consumers.
- Owns all RAM enables and addresses; the RAM's registered output is the output data stage.

Parameters:
- DATA_W, 32: sample width.
- ADDR_W, 18: RAM address width. Each bank holds 2**(ADDR_W-1) samples.

Ports:
- iclk, input, 1: single clock. Drives both RAM clocks.
- irst_n, input, 1: synchronous reset, active-low.
- iframe_len, input, ADDR_W-1: frame length minus 1. Sampled when a fill starts.
- ivalid, input, 1: input sample valid. No backpressure on this side.
- idata, input, DATA_W: input sample.
- iready, input, 1: downstream ready.
- ovalid, output, 1: output sample valid.
- odata, output, DATA_W: output sample, driven combinationally from iram_rdata.
- olast, output, 1: marks the last sample of a frame.
- oovf, output, 1: sticky overflow flag.
- iovf_clr, input, 1: clears oovf.
- oram_en_wr, output, 1: RAM write enable.
- oram_wr_addr, output, ADDR_W: RAM write address.
- oram_wdata, output, DATA_W: RAM write data.
- oram_en_rd, output, 1: RAM read enable.
- oram_r_addr, output, ADDR_W: RAM read address.
- iram_rdata, input, DATA_W: RAM registered read data (1-cycle latency).

Behaviour:
- Reset (irst_n=0 at posedge):
  - All of these are 0: ovalid, olast, oovf, oram_en_wr, oram_en_rd, both addresses, bank_full[1:0], wr_bank, rd_bank.
  - Both FSMs go to IDLE.
  - Reset mid-frame discards all buffered data.
- Write FSM:
  - W_IDLE:
    - Condition: ivalid && !bank_full[wr_bank].
    - Action: latch len=iframe_len, write idata at {wr_bank,0}, wcnt=1, go to W_FILL.
    - A frame with len=0 completes on this same sample; go straight to bank_full set / W_IDLE.
  - W_FILL:
    - Each ivalid writes at {wr_bank,wcnt}.
    - The write at wcnt==len sets bank_full[wr_bank], toggles wr_bank, returns to W_IDLE.
  - The write path is combinational: oram_en_wr = accepted ivalid, oram_wdata = idata, zero latency.
  - Overflow: ivalid in W_IDLE with the target bank full → sample dropped, oovf set.
  - Data in W_FILL is never dropped.
- Read FSM:
  - R_IDLE:
    - Condition: bank_full[rd_bank].
    - Action: latch the frame length for rd_bank (stored per bank at fill completion), rcnt=0, go to R_READ.
  - R_READ:
    - advance = !ovalid || iready.
    - oram_en_rd = advance, oram_r_addr = {rd_bank,rcnt}.
    - On advance: ovalid<=1 next cycle, olast<=(rcnt==len), rcnt++.
    - After issuing rcnt==len, go to R_DRAIN.
  - R_DRAIN:
    - Wait for ovalid&&iready on the olast beat.
    - Then clear bank_full[rd_bank], toggle rd_bank, ovalid<=0, return to R_IDLE.
  - While ovalid && !iready: oram_en_rd=0, so the RAM holds odata stable and olast is held.
  - Throughput is 1 sample/clk under continuous iready.
  - First-sample latency is 2 clocks from the fill-complete write: bank_full visible 1 clk later, then the RAM read takes 1 clk.
- Simultaneous events:
  - A bank freed by R_DRAIN on cycle N is usable by the write FSM from cycle N+1. A write waiting in W_IDLE at N drops that sample and flags oovf.
  - iovf_clr together with a new overflow: set wins.
- Frame length change while a fill is in progress: ignored until the next fill.
- Bank wrap: addresses never cross the bank MSB, because len ≤ 2**(ADDR_W-1)-1.

Optional Feature:
- Macro: BUFFER_PINGPONG_CTRL_OVF_CNT_EN.
- Defined:
  - Adds output oovf_cnt[15:0], counting dropped samples.
  - Saturates at 16'hFFFF.
  - Cleared by iovf_clr and by reset.
  - A drop coinciding with iovf_clr loads 1.
- Undefined: port and counter absent; oovf unchanged.

Decomposition:
- Package buffer_pingpong_pkg:
  - Write FSM enum: W_IDLE, W_FILL.
  - Read FSM enum: R_IDLE, R_READ, R_DRAIN.
  - Localparam BANK_W = ADDR_W-1 helper function.
- No sub-module: write and read FSMs live in one module. buffer_ram is instantiated only in benches and top level.

Test Plan:
- ADDR_W=4, iframe_len=3, 8 continuous ivalid samples 1..8, iready=1 → both banks filled. Output 1,2,3,4 then 5,6,7,8, olast on 4 and 8, oovf=0.
- iready toggled 1/0 every clk during readout → no sample lost or duplicated. odata/olast stable while !iready.
- iready=0 and 12 samples with len=3 → samples 9..12 dropped, oovf=1 (oovf_cnt=4 with the macro defined). iovf_clr → oovf=0.
- iframe_len=0 → each ivalid forms a 1-sample frame with olast=1 on every beat.
- irst_n=0 for 1 clk mid-readout → all outputs 0 next clk. The next frame starts at address {0,0}.
- Bank freed on the same cycle a new ivalid arrives in W_IDLE → sample dropped, oovf=1, next ivalid accepted into the freed bank.
